// File: rtl/vtg_pkg.sv
// vtg_pkg: shared types and constants for the video timing generator.
//   - mode_e   : test-pattern selector
//   - state_e  : run/stop controller states
//   - C_*      : 24-bit {R,G,B} colour constants
//   - LUMA_*   : integer luma weights (sum 256) and the luma() helper
package vtg_pkg;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_GRAD  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_SOLID = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_e;

  localparam logic [23:0] C_WHITE = 24'hFFFFFF;
  localparam logic [23:0] C_RED   = 24'hFF0000;
  localparam logic [23:0] C_GREEN = 24'h00FF00;
  localparam logic [23:0] C_BLUE  = 24'h0000FF;
  localparam logic [23:0] C_BLACK = 24'h000000;

  localparam logic [7:0] LUMA_R = 8'd77;
  localparam logic [7:0] LUMA_G = 8'd151;
  localparam logic [7:0] LUMA_B = 8'd28;

  // Weights sum to 256, so the worst case 256*255 still fits in 16 bits.
  function automatic logic [7:0] luma(input logic [23:0] rgb);
    logic [15:0] acc;
    acc = 16'(LUMA_R) * 16'(rgb[23:16])
        + 16'(LUMA_G) * 16'(rgb[15:8])
        + 16'(LUMA_B) * 16'(rgb[7:0]);
    return acc[15:8];
  endfunction

endpackage

// File: rtl/vtg_pattern_gen.sv
// vtg_pattern_gen: combinational test-pattern source.
// Ports:
//   h_cnt_i / v_cnt_i : raster counters (CNT_W must be >= 8)
//   mode_i            : pattern selector (frame-stable shadow copy)
//   solid_i           : {R,G,B} colour for the solid pattern
//   rgb_o             : {R,G,B} pattern colour (not masked by DE)
// Build option: define VTG_GRAY_EN to output the luma of the pattern on
// all three channels instead of the colour.
module vtg_pattern_gen
  import vtg_pkg::*;
#(
  parameter int H_VISIBLE = 1920,
  parameter int CNT_W     = 12
) (
  input  logic [CNT_W-1:0] h_cnt_i,
  input  logic [CNT_W-1:0] v_cnt_i,
  input  mode_e            mode_i,
  input  logic [23:0]      solid_i,
  output logic [23:0]      rgb_o
);

  // Right-hand edge of each of the first four colour bars.
  localparam logic [CNT_W-1:0] BAR1 = CNT_W'((1 * H_VISIBLE) / 5);
  localparam logic [CNT_W-1:0] BAR2 = CNT_W'((2 * H_VISIBLE) / 5);
  localparam logic [CNT_W-1:0] BAR3 = CNT_W'((3 * H_VISIBLE) / 5);
  localparam logic [CNT_W-1:0] BAR4 = CNT_W'((4 * H_VISIBLE) / 5);

  logic [23:0] pat;

  always_comb begin
    pat = C_BLACK;
    case (mode_i)
      MODE_BARS: begin
        if (h_cnt_i < BAR1)      pat = C_WHITE;
        else if (h_cnt_i < BAR2) pat = C_RED;
        else if (h_cnt_i < BAR3) pat = C_GREEN;
        else if (h_cnt_i < BAR4) pat = C_BLUE;
        else                     pat = C_BLACK;
      end
      MODE_GRAD:  pat = {h_cnt_i[7:0] + v_cnt_i[7:0], h_cnt_i[7:0], v_cnt_i[7:0]};
      MODE_CHECK: pat = (h_cnt_i[6] ^ v_cnt_i[6]) ? C_WHITE : C_BLACK;
      MODE_SOLID: pat = solid_i;
      default:    pat = C_BLACK;
    endcase
  end

`ifdef VTG_GRAY_EN
  assign rgb_o = {3{luma(pat)}};
`else
  assign rgb_o = pat;
`endif

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator with built-in test patterns.
// Ports:
//   clk, rst        : pixel clock, synchronous active-high reset
//   en              : run request; start/stop happen on frame boundaries
//   mode, solid_rgb : pattern select and solid colour (latched per frame)
//   r_o/g_o/b_o     : pixel colour, zero outside active video
//   de/hsync/vsync  : active video and syncs (sync levels set by *_POL)
//   x_o/y_o         : current counter position
//   sof/eol         : start-of-frame / end-of-active-line strobes
//   busy            : generator is not idle
// All outputs are registered with one cycle of latency and mutually aligned.
// Build option VTG_GRAY_EN (see vtg_pattern_gen) selects luma output.
module video_timing_gen
  import vtg_pkg::*;
#(
  parameter int   H_VISIBLE = 1920,
  parameter int   H_FRONT   = 88,
  parameter int   H_SYNC    = 44,
  parameter int   H_BACK    = 148,
  parameter int   V_VISIBLE = 1080,
  parameter int   V_FRONT   = 3,
  parameter int   V_SYNC    = 5,
  parameter int   V_BACK    = 37,
  parameter logic HS_POL    = 1'b1,
  parameter logic VS_POL    = 1'b1,
  parameter int   CNT_W     = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [23:0]      solid_rgb,
  output logic [7:0]       r_o,
  output logic [7:0]       g_o,
  output logic [7:0]       b_o,
  output logic             de,
  output logic             hsync,
  output logic             vsync,
  output logic [CNT_W-1:0] x_o,
  output logic [CNT_W-1:0] y_o,
  output logic             sof,
  output logic             eol,
  output logic             busy
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS   = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS   = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  mode_e            mode_q, mode_d;
  logic [23:0]      solid_q, solid_d;

  logic             line_end, frame_end, active;
  logic [23:0]      pat_rgb;

  assign line_end  = (h_q == H_LAST);
  assign frame_end = line_end && (v_q == V_LAST);
  assign active    = (state_q != ST_IDLE);

  // Controller and counters. STOP keeps scanning so the frame in flight
  // always completes; a returning en cancels the stop without any gap.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    if (active) begin
      if (line_end) begin
        h_d = '0;
        v_d = frame_end ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end else begin
      h_d = '0;
      v_d = '0;
    end
    case (state_q)
      ST_IDLE: if (en) state_d = ST_RUN;
      ST_RUN:  if (!en) state_d = ST_STOP;
      ST_STOP: begin
        if (en)             state_d = ST_RUN;
        else if (frame_end) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pattern settings are sampled only while idle or at the frame wrap so a
  // frame never mixes two patterns.
  always_comb begin
    mode_d  = mode_q;
    solid_d = solid_q;
    if (!active || frame_end) begin
      mode_d  = mode_e'(mode);
      solid_d = solid_rgb;
    end
  end

  vtg_pattern_gen #(
    .H_VISIBLE (H_VISIBLE),
    .CNT_W     (CNT_W)
  ) u_pattern (
    .h_cnt_i (h_q),
    .v_cnt_i (v_q),
    .mode_i  (mode_q),
    .solid_i (solid_q),
    .rgb_o   (pat_rgb)
  );

  // Output decode from the current counter/FSM state, registered below.
  logic             de_d, hs_act, vs_act, sof_d, eol_d;
  logic [23:0]      rgb_d;

  always_comb begin
    de_d   = active && (h_q < H_VIS) && (v_q < V_VIS);
    hs_act = active && (h_q >= HS_BEG) && (h_q < HS_END);
    vs_act = active && (v_q >= VS_BEG) && (v_q < VS_END);
    sof_d  = active && (h_q == '0) && (v_q == '0);
    eol_d  = active && (h_q == H_VIS - 1'b1) && (v_q < V_VIS);
    rgb_d  = de_d ? pat_rgb : 24'h000000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      h_q     <= '0;
      v_q     <= '0;
      mode_q  <= MODE_BARS;
      solid_q <= '0;
      r_o     <= '0;
      g_o     <= '0;
      b_o     <= '0;
      de      <= 1'b0;
      hsync   <= ~HS_POL;
      vsync   <= ~VS_POL;
      x_o     <= '0;
      y_o     <= '0;
      sof     <= 1'b0;
      eol     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      mode_q  <= mode_d;
      solid_q <= solid_d;
      r_o     <= rgb_d[23:16];
      g_o     <= rgb_d[15:8];
      b_o     <= rgb_d[7:0];
      de      <= de_d;
      hsync   <= hs_act ? HS_POL : ~HS_POL;
      vsync   <= vs_act ? VS_POL : ~VS_POL;
      x_o     <= h_q;
      y_o     <= v_q;
      sof     <= sof_d;
      eol     <= eol_d;
      busy    <= active;
    end
  end

endmodule
